adpcma_chan_engine: RTL and testbench



---
 rtl/adpcma_pkg.sv | 40 ++++
 rtl/adpcma_dec.sv | 72 +++++++
 rtl/adpcma_chan_engine.sv | 177 +++++++++++++++++
 tb/tb_adpcma_chan_engine.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/adpcma_pkg.sv
// adpcma_pkg: shared sizes, step/index tables and saturation helper for the
// ADPCM-A channel engine.
package adpcma_pkg;

  localparam int NCH     = 6;
  localparam int ADDR_W  = 16;
  localparam int CNT_W   = 25;
  localparam int ACC_W   = 12;
  localparam int IDX_W   = 6;
  localparam int STEP_W  = 11;
  localparam int IDX_MAX = 48;

  localparam logic [STEP_W-1:0] STEP_TBL [49] = '{
    11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
    11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
    11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
    11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
    11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
    11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
    11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
  };

  // Step-index adjustment indexed by nibble magnitude.
  function automatic logic signed [4:0] idx_delta(input logic [2:0] mag);
    case (mag)
      3'd4:    idx_delta = 5'sd2;
      3'd5:    idx_delta = 5'sd5;
      3'd6:    idx_delta = 5'sd7;
      3'd7:    idx_delta = 5'sd9;
      default: idx_delta = -5'sd1;
    endcase
  endfunction

  function automatic logic [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)       sat16 = 16'h7FFF;
    else if (v < -18'sd32768) sat16 = 16'h8000;
    else                      sat16 = v[15:0];
  endfunction

endpackage

// File: rtl/adpcma_dec.sv
// adpcma_dec: one ADPCM-A decode step, applied to the channel selected by the
// one-hot ch_sel, with acc/idx storage for all channels.
module adpcma_dec
  import adpcma_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen6,
  input  logic [NCH-1:0]   ch_sel,
  input  logic             clr,
  input  logic             step_en,
  input  logic [3:0]       data,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W-1:0]  acc_mem [NCH];
  logic [IDX_W-1:0]  idx_mem [NCH];
  logic [IDX_W-1:0]  idx_cur;
  logic [STEP_W-1:0] step;
  logic [14:0]       prod;
  logic [ACC_W-1:0]  d;
  logic [ACC_W-1:0]  acc_nxt;
  logic signed [7:0] idx_sum;
  logic [IDX_W-1:0]  idx_nxt;

  // Pick the stored state of the channel occupying this slot
  always_comb begin
    acc     = '0;
    idx_cur = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_sel[i]) begin
        acc     = acc_mem[i];
        idx_cur = idx_mem[i];
      end
    end
  end

  // Decode arithmetic: accumulator wraps, index clamps to the table
  always_comb begin
    step    = STEP_TBL[idx_cur];
    prod    = 15'(step) * 15'({data[2:0], 1'b1});
    d       = prod[14:3];
    acc_nxt = data[3] ? (acc - d) : (acc + d);
    idx_sum = $signed({2'b00, idx_cur}) + 8'(idx_delta(data[2:0]));
    if (idx_sum < 8'sd0)       idx_nxt = '0;
    else if (idx_sum > 8'sd48) idx_nxt = IDX_W'(IDX_MAX);
    else                       idx_nxt = idx_sum[IDX_W-1:0];
  end

  // Per-channel state update: clear on key-on, step while playing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        acc_mem[i] <= '0;
        idx_mem[i] <= '0;
      end
    end else if (cen6) begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_sel[i]) begin
          if (clr) begin
            acc_mem[i] <= '0;
            idx_mem[i] <= '0;
          end else if (step_en) begin
            acc_mem[i] <= acc_nxt;
            idx_mem[i] <= idx_nxt;
          end
        end
      end
    end
  end

endmodule

// File: rtl/adpcma_chan_engine.sv
// adpcma_chan_engine: 6-channel time-multiplexed ADPCM-A engine. Slot
// sequencer, START/END registers, key on/off, nibble address counters,
// ROM address outputs and the saturating mixer live here; decoding is in
// adpcma_dec.
module adpcma_chan_engine
  import adpcma_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen6,
  input  logic [15:0] addr_in,
  input  logic [2:0]  addr_ch,
  input  logic        up_start,
  input  logic        up_end,
  input  logic [7:0]  aon_cmd,
  input  logic        up_aon,
  input  logic [3:0]  data,
  input  logic [5:0]  sum_en,
  output logic [19:0] addr_out,
  output logic [3:0]  bank,
  output logic        sel,
  output logic        roe_n,
  output logic [15:0] pcm_dec,
  output logic [15:0] pcm_out
);

  logic [NCH-1:0]     cur_ch, en_ch, nxt_cur;
  logic               match;
  logic [ADDR_W-1:0]  start_r [NCH];
  logic [ADDR_W-1:0]  end_r   [NCH];
  logic [CNT_W-1:0]   cnt     [NCH];
  logic [NCH-1:0]     on, kon_p, koff_p;
  logic [7:0]         aon_q, aon_src;
  logic               aon_pend, apply;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               on_nxt, on_cur, kon_cur, koff_cur;
  logic               dec_clr, dec_step;
  logic [ACC_W-1:0]   acc_cur;
  logic [15:0]        term;
  logic signed [17:0] sum, sum_nxt;

  assign match    = (cur_ch == en_ch);
  assign nxt_cur  = {cur_ch[NCH-2:0], cur_ch[NCH-1]};
  // A command arriving on the apply slot is used directly, displacing any older one.
  assign apply    = cen6 && cur_ch[NCH-1] && (up_aon || aon_pend);
  assign aon_src  = up_aon ? aon_cmd : aon_q;
  assign on_cur   = |(on & cur_ch);
  assign kon_cur  = |(kon_p & cur_ch);
  assign koff_cur = |(koff_p & cur_ch);
  assign dec_clr  = match && kon_cur;
  assign dec_step = match && on_cur && !kon_cur && !koff_cur;

  // Slot rotation: cur_ch every slot, en_ch once per 6-slot group
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ch <= NCH'(1);
      en_ch  <= NCH'(1);
    end else if (cen6) begin
      cur_ch <= nxt_cur;
      if (cur_ch[NCH-1]) en_ch <= {en_ch[0], en_ch[NCH-1:1]};
    end
  end

  // START/END register writes, captured on any clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        start_r[i] <= '0;
        end_r[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (addr_ch == 3'(i)) begin
          if (up_start) start_r[i] <= addr_in;
          if (up_end)   end_r[i]   <= addr_in;
        end
      end
    end
  end

  // Key command holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aon_q    <= '0;
      aon_pend <= 1'b0;
    end else begin
      if (up_aon) aon_q <= aon_cmd;
      if (cen6 && cur_ch[NCH-1]) aon_pend <= 1'b0;
      else if (up_aon)           aon_pend <= 1'b1;
    end
  end

  // Per-channel key handling and nibble counters, advanced in match slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      on     <= '0;
      kon_p  <= '0;
      koff_p <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else if (cen6) begin
      for (int i = 0; i < NCH; i++) begin
        if (match && cur_ch[i]) begin
          if (kon_p[i]) begin
            cnt[i]   <= {start_r[i], 9'd0};
            on[i]    <= 1'b1;
            kon_p[i] <= 1'b0;
          end else if (koff_p[i]) begin
            on[i]     <= 1'b0;
            koff_p[i] <= 1'b0;
          end else if (on[i]) begin
            if (cnt[i] == {end_r[i], 9'h1FF}) on[i] <= 1'b0;
            else                              cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
        // Placed last so a fresh command overrides a same-slot consume on ch5.
        if (apply && aon_src[i]) begin
          kon_p[i]  <= ~aon_src[7];
          koff_p[i] <= aon_src[7];
        end
      end
    end
  end

  // Counter/on state of the channel that owns the next slot
  always_comb begin
    cnt_nxt = '0;
    on_nxt  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (nxt_cur[i]) begin
        cnt_nxt = cnt[i];
        on_nxt  = on[i];
      end
    end
  end

  // Registered ROM bus, presented one slot ahead of the data sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_out <= '0;
      bank     <= '0;
      sel      <= 1'b0;
      roe_n    <= 1'b1;
    end else if (cen6) begin
      addr_out <= cnt_nxt[20:1];
      bank     <= cnt_nxt[24:21];
      sel      <= cnt_nxt[0];
      roe_n    <= ~on_nxt;
    end
  end

  adpcma_dec u_dec (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen6    (cen6),
    .ch_sel  (cur_ch),
    .clr     (dec_clr),
    .step_en (dec_step),
    .data    (data),
    .acc     (acc_cur)
  );

  assign pcm_dec = on_cur ? {acc_cur, 4'b0000} : 16'h0000;
  assign term    = (|(sum_en & cur_ch)) ? pcm_dec : 16'h0000;
  assign sum_nxt = (cur_ch[0] ? 18'sd0 : sum) + 18'($signed(term));

  // Mixer: accumulate one term per slot, publish saturated sum every 6 slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum     <= '0;
      pcm_out <= '0;
    end else if (cen6) begin
      sum <= sum_nxt;
      if (cur_ch[NCH-1]) pcm_out <= sat16(sum_nxt);
    end
  end

endmodule

// File: tb/tb_adpcma_chan_engine.sv
// tb_adpcma_chan_engine: directed, table-driven bench for adpcma_chan_engine.
module tb_adpcma_chan_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen6;
  logic [15:0] addr_in;
  logic [2:0]  addr_ch;
  logic        up_start, up_end;
  logic [7:0]  aon_cmd;
  logic        up_aon;
  logic [3:0]  data;
  logic [5:0]  sum_en;
  logic [19:0] addr_out;
  logic [3:0]  bank;
  logic        sel, roe_n;
  logic [15:0] pcm_dec, pcm_out;

  int checks = 0;
  int passes = 0;
  int slot   = 0;   // bench's own view of the 36-slot frame position

  typedef struct {
    bit          kon;
    logic [3:0]  nib;
    logic [15:0] exp;
  } dvec_t;

  dvec_t dv [16];

  adpcma_chan_engine dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen6     (cen6),
    .addr_in  (addr_in),
    .addr_ch  (addr_ch),
    .up_start (up_start),
    .up_end   (up_end),
    .aon_cmd  (aon_cmd),
    .up_aon   (up_aon),
    .data     (data),
    .sum_en   (sum_en),
    .addr_out (addr_out),
    .bank     (bank),
    .sel      (sel),
    .roe_n    (roe_n),
    .pcm_dec  (pcm_dec),
    .pcm_out  (pcm_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One slot: cen6 high for one clock, low for one clock
  task automatic tick();
    cen6 = 1'b1;
    @(posedge clk); #1;
    cen6 = 1'b0;
    @(posedge clk); #1;
    slot = (slot + 1) % 36;
  endtask

  task automatic run_to(input int target);
    for (int k = 0; k < 36 && slot != target; k++) tick();
  endtask

  task automatic wr_addr(input logic [2:0] ch, input logic [15:0] v, input bit is_end);
    addr_ch = ch;
    addr_in = v;
    if (is_end) up_end = 1'b1; else up_start = 1'b1;
    @(posedge clk); #1;
    up_start = 1'b0;
    up_end   = 1'b0;
  endtask

  task automatic key(input logic [7:0] cmd);
    aon_cmd = cmd;
    up_aon  = 1'b1;
    @(posedge clk); #1;
    up_aon  = 1'b0;
  endtask

  // Key on ch0 and let its match slot (slot 0) consume the key-on
  task automatic keyon_ch0();
    key(8'h01);
    run_to(35);
    tick();
    tick();
  endtask

  initial begin
    bit act;
    rst_n = 1'b0; cen6 = 1'b0; addr_in = '0; addr_ch = '0;
    up_start = 1'b0; up_end = 1'b0; aon_cmd = '0; up_aon = 1'b0;
    data = '0; sum_en = '0;

    dv[0]  = '{1'b1, 4'h7, 16'h01E0};
    dv[1]  = '{1'b0, 4'h8, 16'h01A0};
    dv[2]  = '{1'b1, 4'h8, 16'hFFE0};
    dv[3]  = '{1'b0, 4'h8, 16'hFFC0};
    dv[4]  = '{1'b1, 4'h7, 16'h01E0};
    dv[5]  = '{1'b0, 4'h7, 16'h0630};
    dv[6]  = '{1'b0, 4'h7, 16'h1080};
    dv[7]  = '{1'b0, 4'h7, 16'h28F0};
    dv[8]  = '{1'b0, 4'h7, 16'h62D0};
    dv[9]  = '{1'b0, 4'h7, 16'hEB70};
    dv[10] = '{1'b0, 4'h7, 16'hA150};
    dv[11] = '{1'b0, 4'h7, 16'h5730};
    dv[12] = '{1'b0, 4'hF, 16'hA150};
    dv[13] = '{1'b0, 4'h4, 16'h0E70};
    dv[14] = '{1'b0, 4'h3, 16'h6350};
    dv[15] = '{1'b0, 4'h0, 16'h6E50};

    repeat (3) @(posedge clk);
    #1;
    check("rst addr_out", 32'(addr_out), 32'h0);
    check("rst bank",     32'(bank),     32'h0);
    check("rst sel",      32'(sel),      32'h0);
    check("rst roe_n",    32'(roe_n),    32'h1);
    check("rst pcm_dec",  32'(pcm_dec),  32'h0);
    check("rst pcm_out",  32'(pcm_out),  32'h0);
    rst_n = 1'b1;
    slot  = 0;

    // Decoder vectors on ch0: each step consumed at slot 0, viewed at slot 6
    for (int i = 0; i < 16; i++) begin
      if (dv[i].kon) keyon_ch0();
      data = dv[i].nib;
      run_to(0);
      tick();
      run_to(6);
      check($sformatf("dec vec%0d pcm_dec", i), 32'(pcm_dec), 32'(dv[i].exp));
    end

    // Bank / address mapping of a high START block
    wr_addr(3'd0, 16'hABCD, 1'b0);
    keyon_ch0();
    run_to(6);
    check("bank hi start", 32'(bank),     32'hA);
    check("addr hi start", 32'(addr_out), 32'hBCD00);
    check("sel hi start",  32'(sel),      32'h0);
    check("roe hi start",  32'(roe_n),    32'h0);

    // START=END=0x0010: exactly 512 nibbles, then stop
    data = 4'h7;
    wr_addr(3'd0, 16'h0010, 1'b0);
    wr_addr(3'd0, 16'h0010, 1'b1);
    keyon_ch0();
    for (int n = 0; n < 512; n++) begin
      run_to(0);
      check($sformatf("rom nib%0d", n), {6'd0, roe_n, bank, addr_out, sel},
            {6'd0, 1'b0, 4'h0, 20'h01000 + 20'(n / 2), 1'(n % 2)});
      tick();
    end
    run_to(0);
    check("roe_n after end", 32'(roe_n),    32'h1);
    check("addr after end",  32'(addr_out), 32'h010FF);
    run_to(6);
    check("pcm_dec after end", 32'(pcm_dec), 32'h0);

    // Mixer: ch0 and ch1 both keyed from one apply at slot 35
    sum_en = 6'b000011;
    run_to(30);
    key(8'h03);
    run_to(0);
    repeat (222) tick();
    check("mix sat pcm_out",  32'(pcm_out), 32'h7FFF);
    check("mix ch0 pcm_dec",  32'(pcm_dec), 32'hEB70);
    run_to(12);
    check("mix sum pcm_out",  32'(pcm_out), 32'h4E40);
    sum_en = 6'b000001;
    run_to(18);
    check("mix en01 pcm_out", 32'(pcm_out), 32'hEB70);
    sum_en = 6'b000010;
    run_to(24);
    check("mix en10 pcm_out", 32'(pcm_out), 32'h62D0);

    // Key-off ch0 (0x81) while ch1 keeps playing
    key(8'h81);
    run_to(0);
    check("koff ch0 before match", 32'(roe_n), 32'h0);
    tick();
    run_to(6);
    check("koff ch0 roe_n",   32'(roe_n),   32'h1);
    check("koff ch0 pcm_dec", 32'(pcm_dec), 32'h0);
    run_to(7);
    check("koff ch1 roe_n",   32'(roe_n),   32'h0);
    check("koff ch1 pcm_dec", 32'(pcm_dec), 32'hEB70);

    // Asynchronous reset during playback
    rst_n = 1'b0;
    #1;
    check("async rst roe_n",    32'(roe_n),    32'h1);
    check("async rst addr_out", 32'(addr_out), 32'h0);
    check("async rst pcm_dec",  32'(pcm_dec),  32'h0);
    check("async rst pcm_out",  32'(pcm_out),  32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    slot  = 0;
    sum_en = 6'b111111;
    act = 1'b0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (roe_n !== 1'b1 || pcm_out !== 16'h0 || pcm_dec !== 16'h0) act = 1'b1;
    end
    check("no resume after rst", 32'(act), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
